call_stack: RTL and testbench
=============================

// Module: call_stack
// PURPOSE
//   Hardware return-address stack that services the PUSH/POP requests issued by the
//   instruction decoder on CALL/RETURN. Reports FULL/EMPTY back on stack_flags.
//   Sits between the decoder and the program-counter jump mux:
//     - CALL pushes the return address.
//     - RETURN pops it and presents it as the jump target.
//   Protects itself against overflow and underflow, and flags each with a sticky error.
// PARAMETERS
//   DEPTH       8   number of entries; power of two, >=2
//   ADDR_WIDTH  8   width of a stored return address (PC width)
//   CNT_WIDTH   4   $clog2(DEPTH)+1; occupancy counter width
// PORTS
//   clk            in   1           rising-edge clock
//   rst_n          in   1           asynchronous, active-low reset
//   stack_control  in   2           {PUSH,POP}, sampled every rising edge
//   push_addr      in   ADDR_WIDTH  return address written on PUSH
//   clr_err        in   1           synchronous clear of ovf/udf
//   stack_flags    out  2           {FULL,EMPTY}, decoded from registered count
//   pop_addr       out  ADDR_WIDTH  registered address of last successful POP
//   pop_valid      out  1           1-cycle pulse; pop_addr updated this cycle
//   count          out  CNT_WIDTH   current occupancy, 0..DEPTH
//   ovf            out  1           sticky: PUSH attempted while FULL
//   udf            out  1           sticky: POP attempted while EMPTY
// BEHAVIOUR
//   Reset (rst_n low, async)
//     - count=0, stack_flags=2'b01, pop_addr=0, pop_valid=0, ovf=0, udf=0.
//     - Storage array is not cleared.
//     - Reset mid-operation discards all entries immediately.
//   Storage and flags
//     - Storage is an array mem[0..DEPTH-1] plus an internal top pointer sp = count.
//     - FULL = (count==DEPTH); EMPTY = (count==0). Flags are purely combinational from
//       count, so they change only after a clock edge.
//   Per rising edge, decided on the pre-edge count:
//     2'b00: no change; pop_valid=0.
//     2'b10 PUSH
//       - not FULL: mem[count]<=push_addr; count+1.
//       - FULL: no write, count unchanged, ovf<=1.
//     2'b01 POP
//       - not EMPTY: pop_addr<=mem[count-1]; count-1; pop_valid<=1.
//       - EMPTY: pop_addr holds, pop_valid=0, udf<=1.
//     2'b11 PUSH+POP (replace top)
//       - not EMPTY: pop_addr<=mem[count-1]; mem[count-1]<=push_addr; count unchanged;
//         pop_valid<=1. This is legal even when FULL, with no ovf.
//       - EMPTY: behaves as PUSH only (write mem[0], count=1), udf<=1, pop_valid=0.
//   Pop timing
//     - Latency: POP request at edge N gives pop_addr/pop_valid valid after edge N,
//       for one cycle only.
//     - pop_addr holds its value until the next successful POP.
//   Pointer rules
//     - count never exceeds DEPTH and never goes below 0.
//     - No wrap-around: overflow is dropped, not circular.
//   Error flags
//     - clr_err=1 clears ovf/udf at the edge.
//     - If a new error occurs in the same cycle as clr_err, the new error wins (flag=1).
//   stack_control is assumed combinational from the decoder; it must be stable before the
//   edge. No internal handshake beyond the flags.
// TESTING  (DEPTH=4, ADDR_WIDTH=8)
//   1. Reset: rst_n=0 mid-cycle with count=3 -> count=0, stack_flags=01, pop_addr=0
//      immediately, without waiting for a clock edge.
//   2. Fill: PUSH 0x11,0x22,0x33,0x44 -> count=4, flags=10.
//      Then PUSH 0x55 -> count=4, ovf=1, and a subsequent POP returns 0x44.
//   3. Drain: POP x4 after test 2 -> pop_addr 0x44,0x33,0x22,0x11, each with
//      pop_valid=1 for one cycle, flags=01.
//      5th POP -> udf=1, pop_valid=0, pop_addr stays 0x11.
//   4. Replace: count=2 (0xA0,0xB0), stack_control=11 with push_addr=0xC0 ->
//      pop_addr=0xB0, count=2; next POP -> 0xC0.
//   5. 11 when EMPTY with push_addr=0x7E -> count=1, udf=1, pop_valid=0;
//      next POP -> 0x7E.
//   6. clr_err with ovf=1 and a simultaneous PUSH while FULL -> ovf stays 1.
//      clr_err alone on the next cycle -> ovf=0, udf=0.

Source files
------------

// File: rtl/call_stack.sv
// Return-address stack for CALL/RETURN: push on CALL, pop on RETURN.
// Overflow and underflow are dropped rather than wrapped, and each sets a sticky error flag.
module call_stack #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            stack_control,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  clr_err,
  output logic [1:0]            stack_flags,
  output logic [ADDR_WIDTH-1:0] pop_addr,
  output logic                  pop_valid,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  ovf,
  output logic                  udf
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic [ADDR_WIDTH-1:0] pop_addr_reg;
  logic                  pop_valid_reg;
  logic                  ovf_reg, udf_reg;

  logic             full, empty;
  logic             wr_en, rd_en, ovf_set, udf_set;
  logic [IDX_W-1:0] wr_idx, top_idx;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign top_idx = IDX_W'(count_reg - ONE);

  // All decisions use the pre-edge occupancy; PUSH+POP on a non-empty stack overwrites the top.
  always_comb begin
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    wr_idx     = IDX_W'(count_reg);
    count_next = count_reg;
    case (stack_control)
      2'b10: begin
        if (!full) begin
          wr_en      = 1'b1;
          count_next = count_reg + ONE;
        end else begin
          ovf_set = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          rd_en      = 1'b1;
          count_next = count_reg - ONE;
        end else begin
          udf_set = 1'b1;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        if (!empty) begin
          rd_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          wr_idx     = '0;
          count_next = ONE;
          udf_set    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      pop_addr_reg  <= '0;
      pop_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      udf_reg       <= 1'b0;
    end else begin
      count_reg     <= count_next;
      pop_valid_reg <= rd_en;
      if (rd_en) begin
        pop_addr_reg <= mem[top_idx];
      end
      // A new error in the same cycle as clr_err takes priority.
      ovf_reg <= ovf_set | (ovf_reg & ~clr_err);
      udf_reg <= udf_set | (udf_reg & ~clr_err);
    end
  end

  assign stack_flags = {full, empty};
  assign pop_addr    = pop_addr_reg;
  assign pop_valid   = pop_valid_reg;
  assign count       = count_reg;
  assign ovf         = ovf_reg;
  assign udf         = udf_reg;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: queue-based reference model, directed scenarios then random traffic.
module tb_call_stack;

  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    stack_control = 2'b00;
  logic [AW-1:0] push_addr = '0;
  logic          clr_err = 1'b0;
  logic [1:0]    stack_flags;
  logic [AW-1:0] pop_addr;
  logic          pop_valid;
  logic [CW-1:0] count;
  logic          ovf, udf;

  call_stack #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stack_control(stack_control), .push_addr(push_addr),
    .clr_err(clr_err), .stack_flags(stack_flags), .pop_addr(pop_addr),
    .pop_valid(pop_valid), .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [AW-1:0] stk[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] m_pop_addr;
  logic          m_pop_valid, m_ovf, m_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every pop_valid pulse must match the oldest expected pop.
  always @(negedge clk) begin
    if (rst_n && pop_valid) begin
      if (exp_q.size() == 0) chk("unexpected_pop_valid", 32'(pop_valid), 32'd0);
      else chk("sb_pop_addr", 32'(pop_addr), 32'(exp_q.pop_front()));
    end
  end

  task automatic model_reset();
    stk.delete();
    exp_q.delete();
    m_pop_addr = '0; m_pop_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic model(input logic [1:0] ctrl, input logic [AW-1:0] addr, input logic clr);
    logic o, u;
    o = 1'b0; u = 1'b0; m_pop_valid = 1'b0;
    case (ctrl)
      2'b10: if (stk.size() < DEPTH) stk.push_back(addr); else o = 1'b1;
      2'b01: if (stk.size() > 0) begin
               m_pop_addr = stk.pop_back(); m_pop_valid = 1'b1; exp_q.push_back(m_pop_addr);
             end else u = 1'b1;
      2'b11: if (stk.size() > 0) begin
               m_pop_addr = stk.pop_back(); stk.push_back(addr);
               m_pop_valid = 1'b1; exp_q.push_back(m_pop_addr);
             end else begin
               stk.push_back(addr); u = 1'b1;
             end
      default: ;
    endcase
    m_ovf = o | (m_ovf & ~clr);
    m_udf = u | (m_udf & ~clr);
  endtask

  task automatic step(input logic [1:0] ctrl, input logic [AW-1:0] addr, input logic clr);
    @(negedge clk);
    stack_control = ctrl; push_addr = addr; clr_err = clr;
    model(ctrl, addr, clr);
    @(posedge clk); #1;
    $display("op=%b addr=%02h clr=%b -> count=%0d flags=%b pop_addr=%02h pv=%b ovf=%b udf=%b",
             ctrl, addr, clr, count, stack_flags, pop_addr, pop_valid, ovf, udf);
    chk("count", 32'(count), 32'(stk.size()));
    chk("flags", 32'(stack_flags), {30'd0, stk.size() == DEPTH, stk.size() == 0});
    chk("pop_valid", 32'(pop_valid), 32'(m_pop_valid));
    chk("pop_addr", 32'(pop_addr), 32'(m_pop_addr));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
    stack_control = 2'b00; clr_err = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("async reset -> count=%0d flags=%b pop_addr=%02h", count, stack_flags, pop_addr);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", 32'(stack_flags), 32'b01);
    chk("rst_pop_addr", 32'(pop_addr), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_ovf_udf", {30'd0, ovf, udf}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset mid-operation with three entries
    step(2'b10, 8'h01, 0); step(2'b10, 8'h02, 0); step(2'b10, 8'h03, 0);
    chk("pre_rst_count", 32'(count), 32'd3);
    async_reset();

    // 2: fill, then overflow
    step(2'b10, 8'h11, 0); step(2'b10, 8'h22, 0); step(2'b10, 8'h33, 0); step(2'b10, 8'h44, 0);
    chk("fill_flags", 32'(stack_flags), 32'b10);
    step(2'b10, 8'h55, 0);
    chk("ovf_set", 32'(ovf), 32'd1);

    // 3: drain, then underflow
    step(2'b01, 8'h00, 0);
    chk("drain_first", 32'(pop_addr), 32'h44);
    step(2'b01, 8'h00, 0); step(2'b01, 8'h00, 0); step(2'b01, 8'h00, 0);
    chk("drain_last", 32'(pop_addr), 32'h11);
    step(2'b01, 8'h00, 0);
    chk("udf_hold_addr", 32'(pop_addr), 32'h11);

    // 4: replace top
    step(2'b00, 8'h00, 1);
    step(2'b10, 8'hA0, 0); step(2'b10, 8'hB0, 0);
    step(2'b11, 8'hC0, 0);
    chk("replace_out", 32'(pop_addr), 32'hB0);
    step(2'b01, 8'h00, 0);
    chk("replace_new_top", 32'(pop_addr), 32'hC0);

    // 5: push+pop on empty
    step(2'b01, 8'h00, 0);
    step(2'b11, 8'h7E, 0);
    step(2'b01, 8'h00, 0);
    chk("empty_replace_pop", 32'(pop_addr), 32'h7E);

    // 6: clear racing a new overflow, then plain clear
    for (int i = 0; i < DEPTH; i++) step(2'b10, 8'(8'h60 + i), 0);
    step(2'b10, 8'h99, 0);
    step(2'b10, 8'h9A, 1);
    chk("clr_vs_new_ovf", 32'(ovf), 32'd1);
    step(2'b00, 8'h00, 1);
    chk("clr_alone", {30'd0, ovf, udf}, 32'd0);
    step(2'b11, 8'hD5, 0);

    // random traffic with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else step(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
